// File: rtl/jump_ctrl.sv
// Control-flow resolution for the PC: LUT-based absolute jumps, flag-based skips,
// and call/return through a small hardware return-address stack.
module jump_ctrl #(
  parameter int PW          = 10,
  parameter int LUT_DEPTH   = 16,
  parameter int STACK_DEPTH = 4,
  localparam int IW         = $clog2(LUT_DEPTH)
) (
  input  logic          CLK,
  input  logic          init,
  input  logic [PW-1:0] pc,
  input  logic          halt,
  input  logic [2:0]    op,
  input  logic [IW-1:0] idx,
  input  logic          cmp_in,
  input  logic [PW-1:0] lut_wdata,
  output logic          jump_en,
  output logic          branch_en,
  output logic [PW-1:0] destination,
  output logic          flag,
  output logic          stack_err
);

  localparam int SPW  = $clog2(STACK_DEPTH + 1);
  localparam int STKW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [SPW-1:0] SP_FULL = SPW'(STACK_DEPTH);

  typedef enum logic [2:0] {
    OP_NOP  = 3'b000,
    OP_JMP  = 3'b001,
    OP_CALL = 3'b010,
    OP_RET  = 3'b011,
    OP_SKPT = 3'b100,
    OP_SKPF = 3'b101,
    OP_SETF = 3'b110,
    OP_LUTW = 3'b111
  } op_e;

  logic [PW-1:0]  lut_q [LUT_DEPTH];
  logic [PW-1:0]  lut_d [LUT_DEPTH];
  logic [PW-1:0]  stk_q [STACK_DEPTH];
  logic [PW-1:0]  stk_d [STACK_DEPTH];
  logic [SPW-1:0] sp_q, sp_d;
  logic           flag_q, flag_d;
  logic           stack_err_q, stack_err_d;

  logic [STKW-1:0] push_idx;
  logic [STKW-1:0] top_idx;
  logic [PW-1:0]   ret_addr;

  assign push_idx = STKW'(sp_q);
  assign top_idx  = STKW'(sp_q - 1'b1);
  assign ret_addr = pc + 1'b1;

  always_comb begin
    lut_d       = lut_q;
    stk_d       = stk_q;
    sp_d        = sp_q;
    flag_d      = flag_q;
    stack_err_d = stack_err_q;
    jump_en     = 1'b0;
    branch_en   = 1'b0;
    destination = '0;

    // Outputs are held at 0 during init so the PC never sees a stale jump.
    if (!init && !halt) begin
      unique case (op_e'(op))
        OP_NOP: ;
        OP_JMP: begin
          jump_en     = 1'b1;
          destination = lut_q[idx];
        end
        OP_CALL: begin
          jump_en     = 1'b1;
          destination = lut_q[idx];
          if (sp_q == SP_FULL) begin
            stack_err_d = 1'b1;
          end else begin
            stk_d[push_idx] = ret_addr;
            sp_d            = sp_q + 1'b1;
          end
        end
        OP_RET: begin
          if (sp_q == '0) begin
            stack_err_d = 1'b1;
          end else begin
            jump_en     = 1'b1;
            destination = stk_q[top_idx];
            sp_d        = sp_q - 1'b1;
          end
        end
        OP_SKPT: branch_en = flag_q;
        OP_SKPF: branch_en = ~flag_q;
        OP_SETF: flag_d = cmp_in;
        OP_LUTW: lut_d[idx] = lut_wdata;
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge init) begin
    if (init) begin
      for (int i = 0; i < LUT_DEPTH; i++) lut_q[i] <= '0;
      for (int i = 0; i < STACK_DEPTH; i++) stk_q[i] <= '0;
      sp_q        <= '0;
      flag_q      <= 1'b0;
      stack_err_q <= 1'b0;
    end else begin
      lut_q       <= lut_d;
      stk_q       <= stk_d;
      sp_q        <= sp_d;
      flag_q      <= flag_d;
      stack_err_q <= stack_err_d;
    end
  end

  assign flag      = flag_q;
  assign stack_err = stack_err_q;

endmodule

// File: tb/tb_jump_ctrl.sv
// Bench for jump_ctrl: directed scenarios plus randomized ops against a queue-based model.
module tb_jump_ctrl;

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_JMP  = 3'd1;
  localparam logic [2:0] OP_CALL = 3'd2;
  localparam logic [2:0] OP_RET  = 3'd3;
  localparam logic [2:0] OP_SKPT = 3'd4;
  localparam logic [2:0] OP_SKPF = 3'd5;
  localparam logic [2:0] OP_SETF = 3'd6;
  localparam logic [2:0] OP_LUTW = 3'd7;

  logic       CLK;
  logic       init;
  logic [9:0] pc;
  logic       halt;
  logic [2:0] op;
  logic [3:0] idx;
  logic       cmp_in;
  logic [9:0] lut_wdata;
  logic       jump_en;
  logic       branch_en;
  logic [9:0] destination;
  logic       flag;
  logic       stack_err;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [9:0] lut_m [16];
  logic [9:0] stk_m [$];
  logic       flag_m;
  logic       err_m;
  logic       exp_j, exp_b;
  logic [9:0] exp_d;

  jump_ctrl dut (
    .CLK(CLK), .init(init), .pc(pc), .halt(halt), .op(op), .idx(idx),
    .cmp_in(cmp_in), .lut_wdata(lut_wdata), .jump_en(jump_en),
    .branch_en(branch_en), .destination(destination), .flag(flag),
    .stack_err(stack_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic model_reset();
    for (int i = 0; i < 16; i++) lut_m[i] = '0;
    stk_m.delete();
    flag_m = 1'b0;
    err_m  = 1'b0;
  endtask

  task automatic model_outputs();
    exp_j = 1'b0; exp_b = 1'b0; exp_d = '0;
    if (!halt) begin
      case (op)
        OP_JMP, OP_CALL: begin exp_j = 1'b1; exp_d = lut_m[idx]; end
        OP_RET: if (stk_m.size() > 0) begin exp_j = 1'b1; exp_d = stk_m[$]; end
        OP_SKPT: exp_b = flag_m;
        OP_SKPF: exp_b = !flag_m;
        default: ;
      endcase
    end
  endtask

  task automatic model_update();
    logic [9:0] dummy;
    if (!halt) begin
      case (op)
        OP_CALL: if (stk_m.size() < 4) stk_m.push_back(10'((pc + 1) % 1024)); else err_m = 1'b1;
        OP_RET:  if (stk_m.size() > 0) dummy = stk_m.pop_back(); else err_m = 1'b1;
        OP_SETF: flag_m = cmp_in;
        OP_LUTW: lut_m[idx] = lut_wdata;
        default: ;
      endcase
    end
  endtask

  task automatic drive(input logic [2:0] o, input logic [3:0] i, input logic [9:0] p,
                       input logic h, input logic c, input logic [9:0] w);
    op = o; idx = i; pc = p; halt = h; cmp_in = c; lut_wdata = w;
    #2;
  endtask

  task automatic tick();
    @(posedge CLK);
    model_update();
    #1;
  endtask

  task automatic pulse_init();
    init = 1'b1;
    #1;
    init = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    drive(OP_LUTW, 4'd3, 10'h0, 1'b0, 1'b0, 10'h155); tick();
    drive(OP_SETF, 4'd0, 10'h0, 1'b0, 1'b1, 10'h0);   tick();
    drive(OP_RET,  4'd0, 10'h0, 1'b0, 1'b0, 10'h0);   tick();
    drive(OP_JMP,  4'd3, 10'h0, 1'b0, 1'b0, 10'h0);
    checks++; if (destination !== 10'h155) begin failures++; $display("FAIL pre_reset_dest got=%h want=155", destination); end
    checks++; if (stack_err !== 1'b1) begin failures++; $display("FAIL pre_reset_err got=%b want=1", stack_err); end
    init = 1'b1;
    #1;
    model_reset();
    checks++; if (jump_en !== 1'b0) begin failures++; $display("FAIL reset_jump_en got=%b want=0", jump_en); end
    checks++; if (destination !== 10'h0) begin failures++; $display("FAIL reset_dest got=%h want=000", destination); end
    checks++; if (flag !== 1'b0) begin failures++; $display("FAIL reset_flag got=%b want=0", flag); end
    checks++; if (stack_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b want=0", stack_err); end
    @(negedge CLK);
    init = 1'b0;
    @(posedge CLK); #1;
    drive(OP_JMP, 4'd3, 10'h0, 1'b0, 1'b0, 10'h0);
    checks++; if (jump_en !== 1'b1) begin failures++; $display("FAIL post_reset_jump_en got=%b want=1", jump_en); end
    checks++; if (destination !== 10'h0) begin failures++; $display("FAIL post_reset_lut3 got=%h want=000", destination); end
    tick();
  endtask

  task automatic test_lut();
    drive(OP_LUTW, 4'd5, 10'h0, 1'b0, 1'b0, 10'h2A);
    checks++; if (jump_en !== 1'b0) begin failures++; $display("FAIL lutw_no_jump got=%b want=0", jump_en); end
    tick();
    drive(OP_JMP, 4'd5, 10'h0, 1'b0, 1'b0, 10'h0);
    checks++; if (jump_en !== 1'b1) begin failures++; $display("FAIL lut_jmp5_en got=%b want=1", jump_en); end
    checks++; if (destination !== 10'h2A) begin failures++; $display("FAIL lut_jmp5_dest got=%h want=02a", destination); end
    tick();
    drive(OP_JMP, 4'd4, 10'h0, 1'b0, 1'b0, 10'h0);
    checks++; if (destination !== 10'h0) begin failures++; $display("FAIL lut_jmp4_dest got=%h want=000", destination); end
    tick();
  endtask

  task automatic test_flag();
    drive(OP_SETF, 4'd0, 10'h0, 1'b0, 1'b1, 10'h0); tick();
    checks++; if (flag !== 1'b1) begin failures++; $display("FAIL setf1_flag got=%b want=1", flag); end
    drive(OP_SKPT, 4'd0, 10'h0, 1'b0, 1'b0, 10'h0);
    checks++; if (branch_en !== 1'b1) begin failures++; $display("FAIL skpt_f1 got=%b want=1", branch_en); end
    checks++; if (jump_en !== 1'b0) begin failures++; $display("FAIL skpt_no_jump got=%b want=0", jump_en); end
    tick();
    drive(OP_SKPF, 4'd0, 10'h0, 1'b0, 1'b0, 10'h0);
    checks++; if (branch_en !== 1'b0) begin failures++; $display("FAIL skpf_f1 got=%b want=0", branch_en); end
    tick();
    drive(OP_SETF, 4'd0, 10'h0, 1'b0, 1'b0, 10'h0); tick();
    drive(OP_SKPT, 4'd0, 10'h0, 1'b0, 1'b0, 10'h0);
    checks++; if (branch_en !== 1'b0) begin failures++; $display("FAIL skpt_f0 got=%b want=0", branch_en); end
    tick();
    drive(OP_SKPF, 4'd0, 10'h0, 1'b0, 1'b0, 10'h0);
    checks++; if (branch_en !== 1'b1) begin failures++; $display("FAIL skpf_f0 got=%b want=1", branch_en); end
    tick();
  endtask

  task automatic test_call_ret();
    pulse_init();
    drive(OP_LUTW, 4'd1, 10'h0, 1'b0, 1'b0, 10'h40); tick();
    drive(OP_CALL, 4'd1, 10'h10, 1'b0, 1'b0, 10'h0);
    checks++; if (jump_en !== 1'b1 || destination !== 10'h40) begin failures++; $display("FAIL call_dest got=%b/%h want=1/040", jump_en, destination); end
    tick();
    drive(OP_RET, 4'd0, 10'h45, 1'b0, 1'b0, 10'h0);
    checks++; if (jump_en !== 1'b1 || destination !== 10'h11) begin failures++; $display("FAIL ret_dest got=%b/%h want=1/011", jump_en, destination); end
    tick();
    drive(OP_RET, 4'd0, 10'h12, 1'b0, 1'b0, 10'h0);
    checks++; if (jump_en !== 1'b0) begin failures++; $display("FAIL ret_sp0 got=%b want=0", jump_en); end
    checks++; if (stack_err !== 1'b0) begin failures++; $display("FAIL err_before_underflow got=%b want=0", stack_err); end
    tick();
    checks++; if (stack_err !== 1'b1) begin failures++; $display("FAIL err_underflow got=%b want=1", stack_err); end
  endtask

  task automatic test_stack_limits();
    logic [9:0] want;
    pulse_init();
    drive(OP_LUTW, 4'd2, 10'h0, 1'b0, 1'b0, 10'h77); tick();
    for (int i = 0; i < 5; i++) begin
      drive(OP_CALL, 4'd2, 10'(i), 1'b0, 1'b0, 10'h0);
      checks++; if (jump_en !== 1'b1 || destination !== 10'h77) begin failures++; $display("FAIL call%0d_jump got=%b/%h want=1/077", i, jump_en, destination); end
      tick();
      checks++; if (stack_err !== (i == 4)) begin failures++; $display("FAIL call%0d_err got=%b want=%b", i, stack_err, (i == 4)); end
    end
    for (int i = 0; i < 4; i++) begin
      want = 10'(4 - i);
      drive(OP_RET, 4'd0, 10'h100, 1'b0, 1'b0, 10'h0);
      checks++; if (jump_en !== 1'b1 || destination !== want) begin failures++; $display("FAIL ret%0d got=%b/%h want=1/%h", i, jump_en, destination, want); end
      tick();
    end
    drive(OP_RET, 4'd0, 10'h100, 1'b0, 1'b0, 10'h0);
    checks++; if (jump_en !== 1'b0 || destination !== 10'h0) begin failures++; $display("FAIL ret_empty got=%b/%h want=0/000", jump_en, destination); end
    tick();
    checks++; if (stack_err !== 1'b1) begin failures++; $display("FAIL err_sticky got=%b want=1", stack_err); end
  endtask

  task automatic test_halt_wrap();
    pulse_init();
    drive(OP_LUTW, 4'd6, 10'h0, 1'b0, 1'b0, 10'h200); tick();
    drive(OP_CALL, 4'd6, 10'h20, 1'b0, 1'b0, 10'h0); tick();
    drive(OP_CALL, 4'd6, 10'h30, 1'b1, 1'b0, 10'h0);
    checks++; if (jump_en !== 1'b0 || branch_en !== 1'b0 || destination !== 10'h0) begin failures++; $display("FAIL halt_outputs got=%b%b/%h want=00/000", jump_en, branch_en, destination); end
    tick();
    drive(OP_SETF, 4'd0, 10'h0, 1'b1, 1'b1, 10'h0); tick();
    checks++; if (flag !== 1'b0) begin failures++; $display("FAIL halt_setf got=%b want=0", flag); end
    drive(OP_RET, 4'd0, 10'h201, 1'b0, 1'b0, 10'h0);
    checks++; if (destination !== 10'h21) begin failures++; $display("FAIL halt_sp_kept got=%h want=021", destination); end
    tick();
    drive(OP_RET, 4'd0, 10'h22, 1'b0, 1'b0, 10'h0);
    checks++; if (jump_en !== 1'b0) begin failures++; $display("FAIL halt_no_push got=%b want=0", jump_en); end
    tick();
    drive(OP_CALL, 4'd6, 10'h3FF, 1'b0, 1'b0, 10'h0); tick();
    drive(OP_RET, 4'd0, 10'h200, 1'b0, 1'b0, 10'h0);
    checks++; if (jump_en !== 1'b1 || destination !== 10'h000) begin failures++; $display("FAIL wrap_ret got=%b/%h want=1/000", jump_en, destination); end
    tick();
  endtask

  task automatic test_random();
    pulse_init();
    for (int n = 0; n < 500; n++) begin
      if ($urandom_range(0, 59) == 0) pulse_init();
      drive(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 10'($urandom_range(0, 1023)),
            ($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)), 10'($urandom_range(0, 1023)));
      model_outputs();
      checks++; if (jump_en !== exp_j) begin failures++; $display("FAIL rnd%0d_jump_en op=%0d got=%b want=%b", n, op, jump_en, exp_j); end
      checks++; if (branch_en !== exp_b) begin failures++; $display("FAIL rnd%0d_branch_en op=%0d got=%b want=%b", n, op, branch_en, exp_b); end
      checks++; if (destination !== exp_d) begin failures++; $display("FAIL rnd%0d_dest op=%0d got=%h want=%h", n, op, destination, exp_d); end
      checks++; if (flag !== flag_m) begin failures++; $display("FAIL rnd%0d_flag got=%b want=%b", n, flag, flag_m); end
      checks++; if (stack_err !== err_m) begin failures++; $display("FAIL rnd%0d_stack_err got=%b want=%b", n, stack_err, err_m); end
      tick();
    end
  endtask

  initial begin
    init = 1'b1;
    op = OP_NOP; idx = '0; pc = '0; halt = 1'b0; cmp_in = 1'b0; lut_wdata = '0;
    model_reset();
    #12;
    init = 1'b0;
    @(posedge CLK); #1;
    test_reset();
    test_lut();
    test_flag();
    test_call_ret();
    test_stack_limits();
    test_halt_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
